// File: rtl/axi_burst_master_if.sv
// AXI4 channel bundle shared by the burst initiator and any slave-side block.
interface axi_interface;
   logic [5:0]  arid;
   logic [31:0] araddr;
   logic [7:0]  arlen;
   logic [2:0]  arsize;
   logic [1:0]  arburst;
   logic [3:0]  arcache;
   logic        arvalid;
   logic        arready;
   logic [5:0]  rid;
   logic [31:0] rdata;
   logic [1:0]  rresp;
   logic        rlast;
   logic        rvalid;
   logic        rready;
   logic [5:0]  awid;
   logic [31:0] awaddr;
   logic [7:0]  awlen;
   logic [2:0]  awsize;
   logic [1:0]  awburst;
   logic [3:0]  awcache;
   logic        awvalid;
   logic        awready;
   logic [31:0] wdata;
   logic [3:0]  wstrb;
   logic        wlast;
   logic        wvalid;
   logic        wready;
   logic [5:0]  bid;
   logic [1:0]  bresp;
   logic        bvalid;
   logic        bready;

   modport master (
      output arid, araddr, arlen, arsize, arburst, arcache, arvalid,
      input  arready,
      input  rid, rdata, rresp, rlast, rvalid,
      output rready,
      output awid, awaddr, awlen, awsize, awburst, awcache, awvalid,
      input  awready,
      output wdata, wstrb, wlast, wvalid,
      input  wready,
      input  bid, bresp, bvalid,
      output bready
   );

   modport slave (
      input  arid, araddr, arlen, arsize, arburst, arcache, arvalid,
      output arready,
      output rid, rdata, rresp, rlast, rvalid,
      input  rready,
      input  awid, awaddr, awlen, awsize, awburst, awcache, awvalid,
      output awready,
      input  wdata, wstrb, wlast, wvalid,
      output wready,
      output bid, bresp, bvalid,
      input  bready
   );
endinterface

// File: rtl/axi_burst_master.sv
// Single-outstanding AXI4 burst initiator: one client command becomes one
// AR/R or AW/W/B exchange, with length, response and timeout checking.
module axi_burst_master #(
   parameter int unsigned TIMEOUT_CYCLES = 1024,
   parameter logic [5:0]  AXI_ID         = 6'd0
) (
   input  logic         clk,
   input  logic         rst,
   axi_interface.master axi,
   input  logic         req_valid,
   output logic         req_ready,
   input  logic         req_we,
   input  logic [31:0]  req_addr,
   input  logic [7:0]   req_len,
   input  logic         wd_valid,
   output logic         wd_ready,
   input  logic [31:0]  wd_data,
   input  logic [3:0]   wd_strb,
   output logic         rd_valid,
   input  logic         rd_ready,
   output logic [31:0]  rd_data,
   output logic         rd_last,
   output logic         done,
   output logic         err,
   output logic [2:0]   err_code
);
   typedef enum logic [2:0] {S_IDLE, S_AR, S_R, S_AW, S_W, S_B} state_t;

   localparam logic [15:0] TMO_LIM = 16'(TIMEOUT_CYCLES);

   state_t      state_q;
   logic        up_q;      // low until the first cycle after reset release
   logic        drain_q;   // after an R timeout, swallow stray beats in IDLE
   logic [31:0] addr_q;
   logic [7:0]  len_q;
   logic [8:0]  cnt_q;
   logic [15:0] tmo_q;
   logic        done_q;
   logic        err_q;
   logic [2:0]  code_q;

   logic [13:0] span_d;
   logic [13:0] end_d;
   logic        cross_d;
   logic        last_cnt;
   logic        tmo_hit;
   logic        r_hs;
   logic        r_bad;
   logic        b_bad;
   logic        unused_addr_lsb;

   // The burst end address, in bytes within the 4KB page, decides rejection.
   assign span_d   = (14'(req_len) + 14'd1) << 2;
   assign end_d    = 14'({req_addr[11:2], 2'b00}) + span_d;
   assign cross_d  = end_d > 14'd4096;
   assign last_cnt = (cnt_q == {1'b0, len_q});
   assign tmo_hit  = (tmo_q + 16'd1) == TMO_LIM;
   assign r_hs     = axi.rvalid & axi.rready;
   assign r_bad    = (axi.rresp != 2'b00) || (axi.rid != AXI_ID);
   assign b_bad    = (axi.bresp != 2'b00) || (axi.bid != AXI_ID);
   assign unused_addr_lsb = &{1'b0, req_addr[1:0]};

   // Command sequencing, beat counting, timeout and sticky error tracking.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= S_IDLE;
         up_q    <= 1'b0;
         drain_q <= 1'b0;
         addr_q  <= '0;
         len_q   <= '0;
         cnt_q   <= '0;
         tmo_q   <= '0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
         code_q  <= '0;
      end else begin
         up_q   <= 1'b1;
         done_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (req_valid && req_ready) begin
                  addr_q  <= {req_addr[31:2], 2'b00};
                  len_q   <= req_len;
                  cnt_q   <= '0;
                  tmo_q   <= '0;
                  drain_q <= 1'b0;
                  if (cross_d) begin
                     done_q <= 1'b1;
                     err_q  <= 1'b1;
                     code_q <= 3'b010;
                  end else begin
                     err_q   <= 1'b0;
                     code_q  <= 3'b000;
                     state_q <= req_we ? S_AW : S_AR;
                  end
               end
            end
            S_AR: if (axi.arready) state_q <= S_R;
            S_R: begin
               if (r_hs) begin
                  cnt_q <= cnt_q + 9'd1;
                  tmo_q <= '0;
                  // rlast early or missing at the final count are both mismatches
                  if (axi.rlast != last_cnt) begin
                     code_q[1] <= 1'b1;
                     err_q     <= 1'b1;
                  end
                  if (r_bad) begin
                     code_q[0] <= 1'b1;
                     err_q     <= 1'b1;
                  end
                  if (axi.rlast) begin
                     done_q  <= 1'b1;
                     state_q <= S_IDLE;
                  end
               end else if (tmo_hit) begin
                  code_q[2] <= 1'b1;
                  err_q     <= 1'b1;
                  done_q    <= 1'b1;
                  drain_q   <= 1'b1;
                  state_q   <= S_IDLE;
               end else begin
                  tmo_q <= tmo_q + 16'd1;
               end
            end
            S_AW: if (axi.awready) state_q <= S_W;
            S_W: begin
               if (wd_valid && axi.wready) begin
                  cnt_q <= cnt_q + 9'd1;
                  if (last_cnt) state_q <= S_B;
               end
            end
            S_B: begin
               if (axi.bvalid) begin
                  done_q  <= 1'b1;
                  state_q <= S_IDLE;
                  if (b_bad) begin
                     code_q[0] <= 1'b1;
                     err_q     <= 1'b1;
                  end
               end else if (tmo_hit) begin
                  code_q[2] <= 1'b1;
                  err_q     <= 1'b1;
                  done_q    <= 1'b1;
                  state_q   <= S_IDLE;
               end else begin
                  tmo_q <= tmo_q + 16'd1;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign req_ready   = up_q && (state_q == S_IDLE);

   assign axi.arid    = AXI_ID;
   assign axi.araddr  = addr_q;
   assign axi.arlen   = len_q;
   assign axi.arsize  = 3'b010;
   assign axi.arburst = 2'b01;
   assign axi.arcache = 4'b0011;
   assign axi.arvalid = (state_q == S_AR);

   assign axi.rready  = (state_q == S_R) ? rd_ready : ((state_q == S_IDLE) && drain_q);
   assign rd_valid    = (state_q == S_R) && axi.rvalid;
   assign rd_data     = axi.rdata;
   assign rd_last     = axi.rlast;

   assign axi.awid    = AXI_ID;
   assign axi.awaddr  = addr_q;
   assign axi.awlen   = len_q;
   assign axi.awsize  = 3'b010;
   assign axi.awburst = 2'b01;
   assign axi.awcache = 4'b0011;
   assign axi.awvalid = (state_q == S_AW);

   assign axi.wvalid  = (state_q == S_W) && wd_valid;
   assign axi.wdata   = wd_data;
   assign axi.wstrb   = wd_strb;
   assign axi.wlast   = (state_q == S_W) && last_cnt;
   assign wd_ready    = (state_q == S_W) && axi.wready;

   assign axi.bready  = (state_q == S_B);

   assign done        = done_q;
   assign err         = err_q;
   assign err_code    = code_q;
endmodule

// File: tb/tb_axi_burst_master.sv
// Directed bench for axi_burst_master; the bench plays the AXI slave and the
// client, with a queue scoreboard for data beats.
module tb_axi_burst_master;
   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid, req_ready, req_we;
   logic [31:0] req_addr;
   logic [7:0]  req_len;
   logic        wd_valid, wd_ready;
   logic [31:0] wd_data;
   logic [3:0]  wd_strb;
   logic        rd_valid, rd_ready, rd_last;
   logic [31:0] rd_data;
   logic        done, err;
   logic [2:0]  err_code;

   int tests = 0;
   int fails = 0;
   logic [36:0] sb_q[$];

   axi_interface axi_if ();

   axi_burst_master #(.TIMEOUT_CYCLES(16), .AXI_ID(6'd0)) dut (
      .clk(clk), .rst(rst), .axi(axi_if.master),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_addr(req_addr), .req_len(req_len),
      .wd_valid(wd_valid), .wd_ready(wd_ready), .wd_data(wd_data), .wd_strb(wd_strb),
      .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_last(rd_last),
      .done(done), .err(err), .err_code(err_code)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [36:0] obs, input logic [36:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic finish_txn(input logic [2:0] exp_code);
      check("done_pulse", done, 1'b1);
      check("err_code", err_code, exp_code);
      check("err", err, exp_code != 3'b000);
      check("req_ready_done", req_ready, 1'b1);
      @(negedge clk);
      check("done_single", done, 1'b0);
      check("sb_empty", sb_q.size(), 0);
   endtask

   task automatic do_read(input logic [31:0] addr, input logic [7:0] len, input int nbeats,
                          input int ar_wait, input bit toggle, input int bad_beat,
                          input logic [2:0] exp_code);
      int beat, n;
      bit pushed;
      logic [31:0] dat;
      logic [36:0] e;
      req_valid = 1'b1; req_we = 1'b0; req_addr = addr; req_len = len; rd_ready = 1'b1;
      #1 check("req_ready", req_ready, 1'b1);
      @(negedge clk);
      req_valid = 1'b0;
      for (int i = 0; i < ar_wait; i++) begin
         check("arvalid_hold", axi_if.arvalid, 1'b1);
         @(negedge clk);
      end
      check("arvalid", axi_if.arvalid, 1'b1);
      check("araddr", axi_if.araddr, {addr[31:2], 2'b00});
      check("arlen", axi_if.arlen, len);
      check("ar_attr", {axi_if.arsize, axi_if.arburst, axi_if.arcache, axi_if.arid},
            {3'b010, 2'b01, 4'b0011, 6'd0});
      axi_if.arready = 1'b1;
      @(negedge clk);
      axi_if.arready = 1'b0;
      check("arvalid_drop", axi_if.arvalid, 1'b0);
      beat = 0; n = 0; pushed = 1'b0;
      while (beat < nbeats && n < 100) begin
         dat = addr ^ (32'h1111_1111 * 32'(beat + 1));
         if (!pushed) begin
            sb_q.push_back({4'h0, (beat == nbeats - 1), dat});
            pushed = 1'b1;
         end
         axi_if.rvalid = 1'b1; axi_if.rdata = dat; axi_if.rlast = (beat == nbeats - 1);
         axi_if.rresp = (beat == bad_beat) ? 2'b10 : 2'b00; axi_if.rid = 6'd0;
         rd_ready = toggle ? n[0] : 1'b1;
         #1;
         check("rready", axi_if.rready, rd_ready);
         check("rd_valid", rd_valid, 1'b1);
         check("done_busy", done, 1'b0);
         if (rd_ready) begin
            check("sb_has", sb_q.size() != 0, 1'b1);
            if (sb_q.size() != 0) begin
               e = sb_q.pop_front();
               check("rd_beat", {4'h0, rd_last, rd_data}, e);
            end
            beat++;
            pushed = 1'b0;
         end
         @(negedge clk);
         n++;
      end
      check("r_bound", beat, nbeats);
      axi_if.rvalid = 1'b0; axi_if.rlast = 1'b0; axi_if.rresp = 2'b00; rd_ready = 1'b1;
      finish_txn(exp_code);
   endtask

   task automatic do_write(input logic [31:0] addr, input logic [7:0] len, input logic [31:0] d0,
                           input logic [31:0] d1, input logic [3:0] strb, input bit tmo,
                           input logic [1:0] bresp, input logic [5:0] bid, input logic [2:0] exp_code);
      int beat, n;
      bit pushed;
      logic [31:0] dat;
      logic [36:0] e;
      req_valid = 1'b1; req_we = 1'b1; req_addr = addr; req_len = len;
      wd_valid = 1'b1; wd_data = d0; wd_strb = strb; axi_if.wready = 1'b1;
      #1 check("req_ready", req_ready, 1'b1);
      check("wvalid_idle", axi_if.wvalid, 1'b0);
      @(negedge clk);
      req_valid = 1'b0;
      check("awvalid", axi_if.awvalid, 1'b1);
      check("awaddr", axi_if.awaddr, {addr[31:2], 2'b00});
      check("awlen", axi_if.awlen, len);
      check("wvalid_aw", axi_if.wvalid, 1'b0);
      check("wd_ready_aw", wd_ready, 1'b0);
      axi_if.awready = 1'b1;
      @(negedge clk);
      axi_if.awready = 1'b0;
      beat = 0; n = 0; pushed = 1'b0;
      while (beat <= int'(len) && n < 50) begin
         dat = (beat == 0) ? d0 : d1;
         wd_data = dat;
         if (!pushed) begin
            sb_q.push_back({dat, strb, (beat == int'(len))});
            pushed = 1'b1;
         end
         axi_if.wready = (n != 0);
         #1;
         check("wvalid", axi_if.wvalid, 1'b1);
         check("wd_ready", wd_ready, axi_if.wready);
         if (axi_if.wready) begin
            check("sb_has", sb_q.size() != 0, 1'b1);
            if (sb_q.size() != 0) begin
               e = sb_q.pop_front();
               check("w_beat", {axi_if.wdata, axi_if.wstrb, axi_if.wlast}, e);
            end
            beat++;
            pushed = 1'b0;
         end
         @(negedge clk);
         n++;
      end
      check("w_bound", beat, int'(len) + 1);
      check("bready", axi_if.bready, 1'b1);
      check("wvalid_b", axi_if.wvalid, 1'b0);
      check("done_b", done, 1'b0);
      if (tmo) begin
         n = 0;
         while (!done && n < 40) begin
            @(negedge clk);
            n++;
         end
         check("b_timeout_cycles", n, 16);
      end else begin
         repeat (2) @(negedge clk);
         axi_if.bvalid = 1'b1; axi_if.bresp = bresp; axi_if.bid = bid;
         @(negedge clk);
         axi_if.bvalid = 1'b0; axi_if.bresp = 2'b00; axi_if.bid = 6'd0;
      end
      wd_valid = 1'b0;
      finish_txn(exp_code);
   endtask

   initial begin
      int n;
      rst = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_len = '0;
      wd_valid = 1'b0; wd_data = '0; wd_strb = '0; rd_ready = 1'b0;
      axi_if.arready = 1'b0; axi_if.awready = 1'b0; axi_if.wready = 1'b0;
      axi_if.rvalid = 1'b0; axi_if.rdata = '0; axi_if.rresp = 2'b00; axi_if.rlast = 1'b0;
      axi_if.rid = 6'd0; axi_if.bvalid = 1'b0; axi_if.bresp = 2'b00; axi_if.bid = 6'd0;
      repeat (3) @(negedge clk);
      check("rst_valids", {axi_if.arvalid, axi_if.awvalid, axi_if.wvalid, axi_if.rready,
                           axi_if.bready}, 5'b0);
      check("rst_flags", {done, err, err_code, rd_valid, wd_ready}, 7'b0);
      check("rst_req_ready", req_ready, 1'b0);
      rst = 1'b1;
      @(negedge clk);
      check("req_ready_up", req_ready, 1'b1);

      do_read(32'h0000_1000, 8'd3, 4, 0, 1'b0, -1, 3'b000);
      do_write(32'h0000_2004, 8'd1, 32'hA5A5_A5A5, 32'h5A5A_5A5A, 4'hF, 1'b0, 2'b00, 6'd0, 3'b000);
      do_read(32'h0000_1100, 8'd3, 2, 0, 1'b0, -1, 3'b010);

      // 4KB crossing: rejected without any address phase
      req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h0000_0FF8; req_len = 8'd3;
      #1 check("req_ready_4k", req_ready, 1'b1);
      @(negedge clk);
      req_valid = 1'b0;
      check("4k_done", done, 1'b1);
      check("4k_code", err_code, 3'b010);
      check("4k_no_ar", axi_if.arvalid, 1'b0);
      check("4k_req_ready", req_ready, 1'b1);
      @(negedge clk);
      check("4k_no_ar2", axi_if.arvalid, 1'b0);
      check("4k_done_drop", done, 1'b0);

      do_read(32'h0000_0FF0, 8'd3, 4, 0, 1'b0, -1, 3'b000);
      do_write(32'h0000_3000, 8'd0, 32'h1234_5678, 32'h0, 4'h3, 1'b1, 2'b00, 6'd0, 3'b100);
      do_read(32'h0000_5000, 8'd3, 4, 5, 1'b1, 0, 3'b001);
      do_read(32'h0000_6000, 8'd1, 3, 0, 1'b0, -1, 3'b010);
      do_write(32'h0000_7008, 8'd1, 32'hDEAD_BEEF, 32'hCAFE_F00D, 4'hA, 1'b0, 2'b00, 6'd1, 3'b001);
      do_read(32'h0000_4003, 8'd0, 1, 0, 1'b0, -1, 3'b000);

      // R timeout, then a stray beat is swallowed in IDLE
      req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h0000_8000; req_len = 8'd1;
      @(negedge clk);
      req_valid = 1'b0;
      axi_if.arready = 1'b1;
      @(negedge clk);
      axi_if.arready = 1'b0;
      n = 0;
      while (!done && n < 40) begin
         @(negedge clk);
         n++;
      end
      check("r_timeout_cycles", n, 16);
      check("r_timeout_code", err_code, 3'b100);
      check("r_timeout_ready", req_ready, 1'b1);
      axi_if.rvalid = 1'b1; axi_if.rlast = 1'b1; axi_if.rdata = 32'hBAD0_0001;
      #1 check("drain_rready", axi_if.rready, 1'b1);
      check("drain_rd_valid", rd_valid, 1'b0);
      @(negedge clk);
      axi_if.rvalid = 1'b0; axi_if.rlast = 1'b0;
      check("drain_no_done", done, 1'b0);
      check("drain_code_sticky", err_code, 3'b100);

      // reset while the address phase is pending
      req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h0000_9000; req_len = 8'd2;
      @(negedge clk);
      req_valid = 1'b0;
      check("pre_rst_arvalid", axi_if.arvalid, 1'b1);
      rst = 1'b0;
      @(negedge clk);
      check("mid_rst_arvalid", axi_if.arvalid, 1'b0);
      check("mid_rst_done", done, 1'b0);
      check("mid_rst_req_ready", req_ready, 1'b0);
      rst = 1'b1;
      @(negedge clk);
      check("post_rst_req_ready", req_ready, 1'b1);
      check("post_rst_flags", {done, err, err_code}, 5'b0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/axi_burst_master.md
# axi_burst_master

AXI4 initiator that turns single-request read or write burst commands from a cache or DMA client into AXI address, data and response handshakes. It keeps one transaction outstanding at a time. It sits between a core-side memory client and any block presenting an `axi_interface` slave, including the simulation memory model and the interconnect. It checks burst length against `rlast`, checks response codes, and enforces a response timeout.

## Interface
- `TIMEOUT_CYCLES`, 1024: cycles allowed in R or B without a beat or response before the transaction is aborted with an error.
- `AXI_ID`, 6'd0: value driven on `arid` and `awid`, and expected on `rid` and `bid`.
- `clk` in 1: the single clock; all logic is on the rising edge.
- `rst` in 1: synchronous, active-low reset; `rst==0` at a rising edge resets the block.
- `axi` `axi_interface.master`: AXI4 initiator port. `ar*`, `aw*`, `w*`, `rready` and `bready` are outputs.
- `req_valid` in 1: command valid.
- `req_ready` out 1: command accepted when high together with `req_valid`.
- `req_we` in 1: 1 = write burst, 0 = read burst.
- `req_addr` in 32: byte address; bits [1:0] are ignored and driven as 0.
- `req_len` in 8: beats minus 1 (0..255).
- `wd_valid` / `wd_ready` in/out 1: client write-data handshake.
- `wd_data` in 32 / `wd_strb` in 4: write beat data and byte strobes.
- `rd_valid` out 1: read beat valid.
- `rd_ready` in 1: client can take a read beat.
- `rd_data` out 32 / `rd_last` out 1: read beat data and last-beat flag.
- `done` out 1: one-cycle pulse when a transaction completes or is aborted.
- `err` out 1: sticky error flag; cleared when the next command is accepted.
- `err_code` out 3: {timeout, length mismatch, SLVERR/DECERR or ID mismatch}; sticky with `err`.

## Operation
- Address channels use fixed attributes: `ar/awsize`=3'b010, `ar/awburst`=2'b01 (INCR), `ar/awcache`=4'b0011.
- State machine states: IDLE, AR, R, AW, W, B. `req_ready` = (state==IDLE).
- Command acceptance in IDLE on `req_valid&req_ready`: the block latches address, length and direction, clears the beat counter, timeout counter, `err` and `err_code`.
  - If `req_addr[11:0] + 4*(req_len+1) > 4096` (4KB crossing), the command is rejected: `done`=1 and `err_code`[1]=1 on the next cycle, and the state stays IDLE.
  - Otherwise the next state is AR when `req_we`=0, or AW when `req_we`=1.
- AR: `arvalid`=1 with the latched `araddr`/`arlen`. On `arready` the state moves to R. `arvalid` never drops before `arready`.
- R:
  - `rready`=`rd_ready`, `rd_valid`=`axi.rvalid`, and `rd_data`/`rd_last` pass through combinationally.
  - Each accepted beat increments the 9-bit beat counter.
  - `rlast` together with count==len is a clean completion.
  - `rlast` with count!=len, or count==len without `rlast`, sets the length-mismatch error. The state still exits on `rlast`.
  - `rresp`!=0 or `rid`!=`AXI_ID` on any beat sets `err_code`[0].
  - Exit on `rlast`: `done` pulses and the state returns to IDLE.
- AW: `awvalid`=1 until `awready`, then the state moves to W.
- W:
  - `wvalid`=`wd_valid`, `wd_ready`=`axi.wready`, `wdata`/`wstrb` pass through, and `wlast`=(count==len).
  - After the last beat is accepted, the state moves to B.
  - `wvalid` is 0 in every state other than W.
- B: `bready`=1. On `bvalid`, `done` pulses, `err_code`[0] is set if `bresp`!=0 or `bid`!=`AXI_ID`, and the state returns to IDLE.
- Timeout:
  - In R and B the 16-bit counter increments each cycle with no handshake and resets on each handshake.
  - When it reaches `TIMEOUT_CYCLES`, the block sets `err_code`[2], pulses `done`, and returns to IDLE.
  - Late beats that arrive afterwards are accepted with `rready`=1 in IDLE and discarded.

## Timing
- Reset values: `arvalid`=`awvalid`=`wvalid`=`rready`=`bready`=0, `done`=0, `err`=0, `err_code`=0, `rd_valid`=0, `wd_ready`=0, state IDLE. `req_ready` rises on the first cycle after `rst` returns high.
- Command accepted at edge N: `arvalid`/`awvalid` is high from cycle N+1.
- `done` is registered. It is high for exactly one cycle, in the cycle after the final `rvalid&rready` (with `rlast`) or `bvalid&bready`. `req_ready` returns in the same cycle as `done`.
- Read beats pass through with zero added latency. There is no buffering, so back-to-back beats are sustained at 1 per cycle.
- Write beats also pass through with zero latency, at 1 per cycle when `wd_valid` and `wready` are both high.
- Minimum transaction lengths from acceptance to `done` with an always-ready slave:
  - Read: 3 + len cycles.
  - Write: 4 + len cycles.
- Reset asserted mid-transaction: all valids drop on the next edge and no `done` is issued.

## Test plan
- Read, addr 0x1000, len 3, slave returns 4 beats with `rlast` on beat 4 -> `araddr`=0x1000, `arlen`=3; 4 `rd_valid` beats forwarded; `done` pulses once; `err`=0.
- Write, addr 0x2004, len 1, data 0xA5A5A5A5 then 0x5A5A5A5A, `bresp`=0 -> `wlast` only on the second beat; `done` pulses after `bvalid`; `err`=0.
- Read, len 3, slave asserts `rlast` on beat 2 -> `err_code`=3'b010, `done` pulses, state returns to IDLE.
- Command with addr 0x0FF8 and len 3 (crosses 4KB) -> no `arvalid` is issued; `done` and `err_code`[1] are set one cycle after acceptance.
- Write with `bvalid` withheld, `TIMEOUT_CYCLES`=16 -> `err_code`=3'b100 after 16 idle cycles in B, `done` pulses, `req_ready`=1.
- Read with `arready` held low for 5 cycles and `rd_ready` toggling -> `arvalid` stays stable; no beat is lost or duplicated; `rresp`=2'b10 on beat 1 sets `err_code`[0].
